sc_sng_pair: RTL and testbench
==============================

# sc_sng_pair

Dual-channel stochastic number generator, directly downstream of the VDC low-discrepancy sequence generator in the SC FIR datapath. It consumes the VDC outputs `out` and `out_re` as two decorrelated random sources. It converts a pair of N-bit binary operands into two unipolar bitstreams over one full-period frame, for the stochastic multipliers (tap weight × sample). It also counts the ones emitted per channel, so the frame result is self-checking against the binary inputs.

## Interface
- N, 12: operand and random-number width; must match the VDC width.
- FRAME_LEN, 2**N: bits per frame; fixed at the VDC period.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new frame; sampled only in IDLE.
- a_in  in  N  channel A operand; latched on an accepted start.
- b_in  in  N  channel B operand; latched on an accepted start.
- rnd  in  N  random value for channel A (VDC `out`); free-running.
- rnd_re  in  N  random value for channel B (VDC `out_re`); free-running.
- bit_a  out  1  channel A stream bit; registered.
- bit_b  out  1  channel B stream bit; registered.
- valid  out  1  bit_a/bit_b are frame bits this cycle.
- last  out  1  final bit of the frame; coincides with valid.
- busy  out  1  frame in progress (state RUN).
- ones_a  out  N+1  count of 1s emitted on bit_a in the current or most recent frame.
- ones_b  out  N+1  same for bit_b.

## Operation
- Two states: IDLE and RUN.
- Frame counter `cnt` is N+1 bits wide.
- Operand registers: a_q and b_q.

- **IDLE**
  - On start=1: latch a_q←a_in and b_q←b_in, clear cnt, ones_a and ones_b, then go to RUN.
  - With no start, outputs hold. ones_a/ones_b keep the last frame's result.
- **RUN, every cycle**
  - bit_a←(a_q > rnd) and bit_b←(b_q > rnd_re), unsigned strict greater-than.
  - valid←1.
  - ones_a←ones_a+(a_q>rnd) and ones_b←ones_b+(b_q>rnd_re).
  - cnt←cnt+1.
- **End of frame**
  - When cnt==FRAME_LEN-1 in RUN, that edge also sets last←1 and moves to IDLE.
  - On the following edge, valid and last clear.
- **Frame result**
  - rnd is a permutation over any FRAME_LEN consecutive cycles, so after last, ones_a==a_q exactly and ones_b==b_q exactly.
  - Max value is 2**N-1; the N+1 width gives headroom.
- **Boundary cases**
  - a_q=0: all-zero stream.
  - a_q=2**N-1: a single 0 per frame, where rnd=2**N-1.
- **start ignored**
  - start in RUN, including the cycle that produces the last bit, is ignored. Operands are not re-latched.
- **Reset**
  - reset=1 at any time, mid-frame included, forces on the next edge: state IDLE, bit_a=bit_b=valid=last=busy=0, ones_a=ones_b=0, cnt=0, a_q=b_q=0.
  - reset overrides start when both are asserted.
- The block does not drive or stall the VDC. Frame alignment to the random sequence phase is arbitrary.

## Timing
- Reset values of all outputs are 0.
- start accepted at edge k:
  - busy=1 after edge k.
  - First valid bit after edge k+1.
  - last=1 (with valid=1) after edge k+FRAME_LEN; busy drops at that same edge.
  - ones_a/ones_b are final after edge k+FRAME_LEN, in the same cycle last is visible.
- Stream bit at edge j uses the rnd/rnd_re values present before edge j. Latency from random input to output is 1 cycle.
- Back-to-back frames: a new start is accepted at edge k+FRAME_LEN+1 at the earliest. The gap between frames is one idle cycle: valid=0 for exactly one cycle when start is held high.
- busy is a registered state decode and has no combinational path from start.

## Test plan
- **Nominal frame:** reset 2 cycles; start with a_in=0x800, b_in=0x400 (N=12), driven by the VDC → exactly 4096 valid cycles, one last pulse, ones_a=2048, ones_b=1024 held until the next start.
- **Extremes:** a_in=0, b_in=0xFFF → bit_a never 1, ones_a=0; bit_b is 0 exactly once, where rnd_re=0xFFF; ones_b=4095.
- **Start while busy:** assert start with new operands (a_in=0x123) at cycle 100 of a frame → ignored; frame completes with the original operands and counts.
- **Reset mid-frame:** reset at cycle 1000 of a frame → next edge all outputs 0 and busy=0. A subsequent start runs a full clean frame with correct counts.
- **Back-to-back:** hold start=1 with a_in=0x001, then 0xFFE → exactly one idle cycle between the frames; ones_a=1, then 4094.
- **Reset with start:** reset and start asserted in the same cycle → IDLE, busy=0, no frame begins.

Source files
------------

// File: rtl/sc_sng_pair.sv
// sc_sng_pair: dual-channel stochastic number generator.
// Converts two N-bit operands into two unipolar bitstreams over one
// FRAME_LEN-bit frame. Each stream bit is (operand > random value), using
// the two decorrelated VDC outputs. The ones emitted on each channel are
// counted, so the frame result can be compared against the operands.

module sc_sng_pair #(
  parameter int N         = 12,
  parameter int FRAME_LEN = 2**N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic [N-1:0] rnd,
  input  logic [N-1:0] rnd_re,
  output logic         bit_a,
  output logic         bit_b,
  output logic         valid,
  output logic         last,
  output logic         busy,
  output logic [N:0]   ones_a,
  output logic [N:0]   ones_b
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter value seen in RUN just before the edge that emits the final bit.
  localparam logic [N:0] LAST_CNT = (N+1)'(FRAME_LEN - 1);

  state_t       state;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N:0]   cnt;
  logic         gt_a;
  logic         gt_b;

  // Comparators: unsigned strict greater-than against this cycle's random values.
  assign gt_a = (a_q > rnd);
  assign gt_b = (b_q > rnd_re);

  // busy decodes the state register only, so start never reaches it combinationally.
  assign busy = (state == RUN);

  // Frame sequencer: latches operands on start, emits one bit per channel per
  // cycle in RUN, counts ones, and flags the final bit of the frame.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later statements see the
  // new cnt/ones values within the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      bit_a  <= 1'b0;
      bit_b  <= 1'b0;
      valid  <= 1'b0;
      last   <= 1'b0;
      ones_a <= '0;
      ones_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          last  <= 1'b0;
          if (start) begin
            a_q    <= a_in;
            b_q    <= b_in;
            cnt    <= '0;
            ones_a <= '0;
            ones_b <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          bit_a  <= gt_a;
          bit_b  <= gt_b;
          valid  <= 1'b1;
          ones_a <= ones_a + (N+1)'(gt_a);
          ones_b <= ones_b + (N+1)'(gt_b);
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            last  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_sng_pair.sv
// tb_sc_sng_pair: directed bench for sc_sng_pair (N=12).
// A free-running bit-reversed counter stands in for the VDC generator; both
// random sources are permutations over any 4096 consecutive cycles.

module tb_sc_sng_pair;

  localparam int N = 12;

  logic          clock;
  logic          reset;
  logic          start;
  logic [N-1:0]  a_in;
  logic [N-1:0]  b_in;
  logic [N-1:0]  rnd;
  logic [N-1:0]  rnd_re;
  logic          bit_a;
  logic          bit_b;
  logic          valid;
  logic          last;
  logic          busy;
  logic [N:0]    ones_a;
  logic [N:0]    ones_b;

  int tests  = 0;
  int failed = 0;

  // Per-run observation counters, all owned by the stimulus process.
  int           n_valid;
  int           n_last;
  int           n_ones_a;
  int           n_ones_b;
  int           n_zero_b;
  logic [N-1:0] zero_b_rnd;
  logic [N-1:0] pre_re;
  logic         got_last;

  logic [N-1:0] vdc_cnt = 12'd37;

  sc_sng_pair #(.N(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .rnd    (rnd),
    .rnd_re (rnd_re),
    .bit_a  (bit_a),
    .bit_b  (bit_b),
    .valid  (valid),
    .last   (last),
    .busy   (busy),
    .ones_a (ones_a),
    .ones_b (ones_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  // VDC stand-in: free-running counter, bit-reversed for out; a fixed XOR
  // offset before reversal gives a second, differently ordered permutation.
  always @(posedge clock) vdc_cnt <= vdc_cnt + 1'b1;

  always_comb begin
    rnd    = bitrev(vdc_cnt);
    rnd_re = bitrev(vdc_cnt ^ 12'hA5C);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid    = 0;
    n_last     = 0;
    n_ones_a   = 0;
    n_ones_b   = 0;
    n_zero_b   = 0;
    zero_b_rnd = '0;
  endtask

  // One clock: note rnd_re as seen before the edge, then sample outputs 1ns after it.
  task automatic tick();
    pre_re = rnd_re;
    @(posedge clock);
    #1;
    if (valid) begin
      n_valid++;
      if (bit_a) n_ones_a++;
      if (bit_b) n_ones_b++;
      else begin
        n_zero_b++;
        zero_b_rnd = pre_re;
      end
    end
    if (last) n_last++;
  endtask

  // Tick until last is seen, bounded; an expired budget is a failed comparison.
  task automatic run_until_last(input string tag, input int budget);
    got_last = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (last) begin
        got_last = 1'b1;
        break;
      end
    end
    check({tag, "_last_seen"}, 32'(got_last), 32'd1);
  endtask

  task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    clear_counts();

    // Reset state
    tick();
    tick();
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_valid",  32'(valid),  32'd0);
    check("rst_last",   32'(last),   32'd0);
    check("rst_bits",   32'({bit_a, bit_b}), 32'd0);
    check("rst_ones_a", 32'(ones_a), 32'd0);
    check("rst_ones_b", 32'(ones_b), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Nominal frame: 0x800 / 0x400
    accept(12'h800, 12'h400);
    check("nom_busy_after_start",  32'(busy),  32'd1);
    check("nom_valid_after_start", 32'(valid), 32'd0);
    clear_counts();
    tick();
    check("nom_first_valid", 32'(valid), 32'd1);
    run_until_last("nom", 5000);
    check("nom_n_valid",   32'(n_valid),  32'd4096);
    check("nom_n_last",    32'(n_last),   32'd1);
    check("nom_last_valid", 32'(valid),   32'd1);
    check("nom_busy_drop", 32'(busy),     32'd0);
    check("nom_ones_a",    32'(ones_a),   32'd2048);
    check("nom_ones_b",    32'(ones_b),   32'd1024);
    check("nom_stream_a",  32'(n_ones_a), 32'd2048);
    check("nom_stream_b",  32'(n_ones_b), 32'd1024);
    tick();
    check("nom_valid_clear", 32'(valid), 32'd0);
    check("nom_last_clear",  32'(last),  32'd0);
    tick();
    tick();
    check("nom_hold_a", 32'(ones_a), 32'd2048);
    check("nom_hold_b", 32'(ones_b), 32'd1024);

    // Extremes: 0 / 0xFFF
    accept(12'h000, 12'hFFF);
    clear_counts();
    run_until_last("ext", 5000);
    check("ext_n_valid",   32'(n_valid),    32'd4096);
    check("ext_stream_a",  32'(n_ones_a),   32'd0);
    check("ext_ones_a",    32'(ones_a),     32'd0);
    check("ext_zero_b",    32'(n_zero_b),   32'd1);
    check("ext_zero_b_at", 32'(zero_b_rnd), 32'hFFF);
    check("ext_ones_b",    32'(ones_b),     32'd4095);
    tick();

    // Start while busy: new operands at cycle 100 must be ignored
    accept(12'h300, 12'h0C0);
    clear_counts();
    for (int i = 0; i < 99; i++) tick();
    a_in  = 12'h123;
    b_in  = 12'h456;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sib_busy", 32'(busy), 32'd1);
    run_until_last("sib", 5000);
    check("sib_n_valid", 32'(n_valid), 32'd4096);
    check("sib_ones_a",  32'(ones_a),  32'd768);
    check("sib_ones_b",  32'(ones_b),  32'd192);
    tick();

    // Reset mid-frame at cycle 1000, then a clean frame
    accept(12'h555, 12'h2AA);
    clear_counts();
    for (int i = 0; i < 1000; i++) tick();
    check("rmf_no_last", 32'(n_last), 32'd0);
    reset = 1'b1;
    tick();
    check("rmf_busy",   32'(busy),   32'd0);
    check("rmf_valid",  32'(valid),  32'd0);
    check("rmf_last",   32'(last),   32'd0);
    check("rmf_bits",   32'({bit_a, bit_b}), 32'd0);
    check("rmf_ones_a", 32'(ones_a), 32'd0);
    check("rmf_ones_b", 32'(ones_b), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("rmf_idle_valid", 32'(valid), 32'd0);
    accept(12'h0F0, 12'hF00);
    clear_counts();
    run_until_last("rmf_clean", 5000);
    check("rmf_clean_n_valid", 32'(n_valid), 32'd4096);
    check("rmf_clean_ones_a",  32'(ones_a),  32'd240);
    check("rmf_clean_ones_b",  32'(ones_b),  32'd3840);
    tick();

    // Back-to-back with start held high
    a_in  = 12'h001;
    b_in  = 12'h7FF;
    start = 1'b1;
    tick();
    clear_counts();
    run_until_last("b2b1", 5000);
    check("b2b1_ones_a",  32'(ones_a), 32'd1);
    check("b2b1_ones_b",  32'(ones_b), 32'd2047);
    a_in = 12'hFFE;
    b_in = 12'h001;
    clear_counts();
    tick();
    check("b2b_gap_valid", 32'(valid), 32'd0);
    check("b2b_gap_busy",  32'(busy),  32'd1);
    tick();
    check("b2b2_first_valid", 32'(valid), 32'd1);
    start = 1'b0;
    run_until_last("b2b2", 5000);
    check("b2b2_n_valid", 32'(n_valid), 32'd4096);
    check("b2b2_ones_a",  32'(ones_a),  32'd4094);
    check("b2b2_ones_b",  32'(ones_b),  32'd1);
    tick();

    // Reset and start together: reset wins, no frame begins
    a_in  = 12'h7AB;
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("rws_busy",  32'(busy),   32'd0);
    check("rws_valid", 32'(valid),  32'd0);
    check("rws_ones",  32'(ones_a), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    tick();
    check("rws_idle_busy",  32'(busy),  32'd0);
    check("rws_idle_valid", 32'(valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
